// File: rtl/data_wishbone_if.sv
// Bridges the core's single-cycle data-RAM port to a Wishbone B3 master, one transfer at a time.
// All bus outputs are registered; stallreq and cpu_data_o are decoded from state and the live ack.
module data_wishbone_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned DW             = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall_i,
    input  logic          flush_i,
    input  logic          cpu_ce_i,
    input  logic          cpu_we_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic [31:0]   cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          stallreq,
    output logic          bus_err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [31:0]   wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic [DW-1:0] rd_buf_q, rd_buf_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          err_q, err_d;
    logic          bus_clear;

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        rd_buf_d   = rd_buf_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        err_d      = 1'b0;
        bus_clear  = 1'b0;
        stallreq   = 1'b0;
        cpu_data_o = '0;

        case (state_q)
            IDLE: begin
                stallreq = cpu_ce_i && !flush_i;
                if (cpu_ce_i && !flush_i) begin
                    cyc_d     = 1'b1;
                    we_d      = cpu_we_i;
                    sel_d     = cpu_sel_i;
                    adr_d     = cpu_addr_i;
                    dat_d     = cpu_data_i;
                    counter_d = '0;
                    state_d   = BUSY;
                end else begin
                    bus_clear = 1'b1;
                end
            end

            BUSY: begin
                stallreq = !wb_ack_i;
                if (wb_ack_i && !we_q) begin
                    cpu_data_o = wb_dat_i;
                end
                if (flush_i) begin
                    bus_clear = 1'b1;
                    state_d   = IDLE;
                end else if (wb_ack_i) begin
                    bus_clear = 1'b1;
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    state_d = (stall_i != 6'b0) ? WAIT_STALL : IDLE;
                end else if (WDOG_EN && counter_q == CNT_MAX) begin
                    // Abort: the core sees a zero load value rather than stale data.
                    bus_clear = 1'b1;
                    rd_buf_d  = '0;
                    err_d     = 1'b1;
                    state_d   = (stall_i != 6'b0) ? WAIT_STALL : IDLE;
                end else if (WDOG_EN) begin
                    counter_d = counter_q + 1'b1;
                end
            end

            WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (flush_i || stall_i == 6'b0) begin
                    state_d = IDLE;
                end
            end

            default: begin
                bus_clear = 1'b1;
                state_d   = IDLE;
            end
        endcase

        if (bus_clear) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
            adr_d = '0;
            dat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            rd_buf_q  <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rd_buf_q  <= rd_buf_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
        end
    end

    // Strobe shares the cycle register: exactly one non-pipelined transfer in flight.
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign bus_err_o = err_q;

endmodule

// File: tb/tb_data_wishbone_if.sv
// Directed bench for data_wishbone_if: per-cycle vector table plus hand-written watchdog and reset sequences.
module tb_data_wishbone_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int checks   = 0;
    int failures = 0;

    data_wishbone_if #(
        .TIMEOUT_CYCLES (4),
        .DW             (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq   (stallreq),
        .bus_err_o  (bus_err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs held during the cycle, outputs expected mid-cycle.
    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        ack;
        logic        e_stallreq;
        logic [31:0] e_data;
        logic        e_cyc;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] stall, input logic flush, input logic ce, input logic we,
                         input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] rdat, input logic ack);
        stall_i    = stall;
        flush_i    = flush;
        cpu_ce_i   = ce;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        cpu_addr_i = addr;
        cpu_data_i = wdat;
        wb_dat_i   = rdat;
        wb_ack_i   = ack;
    endtask

    task automatic expect_out(input string name, input logic e_stallreq, input logic [31:0] e_data,
                              input logic e_cyc, input logic e_we, input logic [3:0] e_sel,
                              input logic [31:0] e_adr, input logic [31:0] e_dat, input logic e_err);
        @(negedge clk);
        chk({name, ".stallreq"}, {31'b0, stallreq},  {31'b0, e_stallreq});
        chk({name, ".cpu_data"}, cpu_data_o,         e_data);
        chk({name, ".cyc"},      {31'b0, wb_cyc_o},  {31'b0, e_cyc});
        chk({name, ".stb"},      {31'b0, wb_stb_o},  {31'b0, e_cyc});
        chk({name, ".we"},       {31'b0, wb_we_o},   {31'b0, e_we});
        chk({name, ".sel"},      {28'b0, wb_sel_o},  {28'b0, e_sel});
        chk({name, ".adr"},      wb_adr_o,           e_adr);
        chk({name, ".dat"},      wb_dat_o,           e_dat);
        chk({name, ".bus_err"},  {31'b0, bus_err_o}, {31'b0, e_err});
        $display("cycle %-14s stallreq=%0b data=%h cyc=%0b we=%0b sel=%h adr=%h dat=%h err=%0b",
                 name, stallreq, cpu_data_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, bus_err_o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(6'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;

        // name, stall, flush, ce, we, sel, addr, wdat, rdat, ack | stallreq, data, cyc, we, sel, adr, dat, err
        vecs = '{
            '{"t1_req",   6'h00, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t1_busy1", 6'h00, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    1'b0},
            '{"t1_busy2", 6'h00, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    1'b0},
            '{"t1_ack",   6'h00, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    32'hDEADBEEF, 1'b1,
              1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0,    1'b0},
            '{"t1_lateack",6'h00,1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    32'hFFFFFFFF, 1'b1,
              1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t2_req",   6'h00, 1'b0, 1'b1, 1'b1, 4'h2, 32'h44, 32'hAB00, 32'h0,        1'b0,
              1'b1, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t2_busy1", 6'h00, 1'b0, 1'b1, 1'b1, 4'h2, 32'h44, 32'hAB00, 32'h0,        1'b0,
              1'b1, 32'h0,        1'b1, 1'b1, 4'h2, 32'h44, 32'hAB00, 1'b0},
            '{"t2_ack",   6'h00, 1'b0, 1'b1, 1'b1, 4'h2, 32'h44, 32'hAB00, 32'h55555555, 1'b1,
              1'b0, 32'h0,        1'b1, 1'b1, 4'h2, 32'h44, 32'hAB00, 1'b0},
            '{"t2_idle",  6'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    32'h0,        1'b0,
              1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t3_req",   6'h0F, 1'b0, 1'b1, 1'b0, 4'hF, 32'h48, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t3_ack",   6'h0F, 1'b0, 1'b1, 1'b0, 4'hF, 32'h48, 32'h0,    32'h12345678, 1'b1,
              1'b0, 32'h12345678, 1'b1, 1'b0, 4'hF, 32'h48, 32'h0,    1'b0},
            '{"t3_wait1", 6'h0F, 1'b0, 1'b1, 1'b0, 4'hF, 32'h48, 32'h0,    32'h0,        1'b0,
              1'b0, 32'h12345678, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t3_wait2", 6'h0F, 1'b0, 1'b1, 1'b0, 4'hF, 32'h48, 32'h0,    32'hCCCCCCCC, 1'b1,
              1'b0, 32'h12345678, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t3_release",6'h00,1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    32'h0,        1'b0,
              1'b0, 32'h12345678, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t3_idle",  6'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    32'h0,        1'b0,
              1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t4_req",   6'h00, 1'b0, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t4_busy1", 6'h00, 1'b0, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b1, 1'b0, 4'hF, 32'h50, 32'h0,    1'b0},
            '{"t4_flush", 6'h00, 1'b1, 1'b1, 1'b0, 4'hF, 32'h50, 32'h0,    32'h0,        1'b0,
              1'b1, 32'h0,        1'b1, 1'b0, 4'hF, 32'h50, 32'h0,    1'b0},
            '{"t4_lateack",6'h00,1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    32'hAAAAAAAA, 1'b1,
              1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t4_ceflush",6'h00,1'b1, 1'b1, 1'b0, 4'hF, 32'h54, 32'h0,    32'h0,        1'b0,
              1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0},
            '{"t4_idle",  6'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    32'h0,        1'b0,
              1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,  32'h0,    1'b0}
        };

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].ce, vecs[i].we, vecs[i].sel,
                  vecs[i].addr, vecs[i].wdat, vecs[i].rdat, vecs[i].ack);
            expect_out(vecs[i].name, vecs[i].e_stallreq, vecs[i].e_data, vecs[i].e_cyc,
                       vecs[i].e_we, vecs[i].e_sel, vecs[i].e_adr, vecs[i].e_dat, vecs[i].e_err);
        end

        // Watchdog (timeout 4) with the pipeline stalled: abort must zero the held load value.
        drive(6'h01, 1'b0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 32'h0, 1'b0);
        expect_out("wd_req", 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            expect_out($sformatf("wd_busy%0d", i), 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 1'b0);
        end
        drive(6'h01, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_out("wd_abort", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        drive(6'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_out("wd_after", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        expect_out("wd_idle", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Reset in the middle of a write.
        drive(6'h00, 1'b0, 1'b1, 1'b1, 4'h3, 32'h70, 32'h99, 32'h0, 1'b0);
        expect_out("rst_req", 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        expect_out("rst_busy", 1'b1, 32'h0, 1'b1, 1'b1, 4'h3, 32'h70, 32'h99, 1'b0);
        rst = 1'b1;
        drive(6'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_out("rst_after", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        // Reset while holding captured read data in the stall wait.
        drive(6'h01, 1'b0, 1'b1, 1'b0, 4'hF, 32'h74, 32'h0, 32'h0, 1'b0);
        expect_out("rs2_req", 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        drive(6'h01, 1'b0, 1'b1, 1'b0, 4'hF, 32'h74, 32'h0, 32'hCAFEF00D, 1'b1);
        expect_out("rs2_ack", 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 4'hF, 32'h74, 32'h0, 1'b0);
        drive(6'h01, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        expect_out("rs2_wait", 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        expect_out("rs2_after", 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_wishbone_if.md
Name: data_wishbone_if

Overview:
- Bridges the CPU core's single-cycle data-RAM port (ce/we/sel/addr/data) to a classic Wishbone B3 master, one transfer at a time.
- Sits directly downstream of the core's MEM-stage memory outputs.
- Holds the pipeline through `stallreq` until the slave acks.
- Captures read data so the core still sees it after a pipeline stall releases.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in BUSY without ack before abort; 0 disables the watchdog.
- DW, 32, data width; fixed at 32 for this core.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- stall_i  in  6  pipeline stall vector from ctrl
- flush_i  in  1  pipeline flush; aborts any transfer
- cpu_ce_i  in  1  data access request from MEM stage
- cpu_we_i  in  1  1=store, 0=load
- cpu_sel_i  in  4  byte lane enables
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data back to MEM stage
- stallreq  out  1  pipeline stall request to ctrl
- bus_err_o  out  1  one-cycle pulse on watchdog abort
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte selects
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE, counter=0, rd_buf=0.
  - All wb_* outputs are registered and cleared to 0; bus_err_o=0.
- States: IDLE, BUSY, WAIT_STALL. All wb_* outputs and bus_err_o are registered.
- IDLE:
  - If cpu_ce_i && !flush_i: next edge latches cpu_addr_i, cpu_data_i, cpu_we_i, cpu_sel_i onto wb_*; sets cyc=stb=1; clears counter; goes to BUSY.
  - Otherwise wb_* hold 0.
- BUSY, checked in this priority order:
  - flush_i=1: clear cyc/stb/we/sel/adr/dat; go to IDLE; no data captured.
  - wb_ack_i=1: clear cyc/stb/we/sel/adr/dat; rd_buf<=wb_dat_i when the access is a read. Go to WAIT_STALL if stall_i!=0, else IDLE.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: clear bus outputs; rd_buf<=32'h0; pulse bus_err_o for one cycle; go to WAIT_STALL if stall_i!=0, else IDLE.
  - Otherwise: counter++, saturating at TIMEOUT_CYCLES-1.
- WAIT_STALL:
  - If flush_i: go to IDLE.
  - Else if stall_i==6'b0: go to IDLE.
  - Else: remain.
- Combinational outputs by state:
  - IDLE: stallreq = cpu_ce_i && !flush_i; cpu_data_o = 0.
  - BUSY: stallreq = !wb_ack_i; cpu_data_o = wb_dat_i when (wb_ack_i && !wb_we_o), else 0.
  - WAIT_STALL: stallreq = 0; cpu_data_o = rd_buf.
- Latency:
  - Minimum load is 2 cycles from cpu_ce_i to data at cpu_data_o (ack in first BUSY cycle).
  - stallreq drops in the same cycle wb_ack_i is seen.
- wb_stb_o==wb_cyc_o at all times. No pipelined or burst transfers; exactly one outstanding cycle.
- A new request is never accepted in the same edge that completes one; IDLE always intervenes for at least one cycle.
- Late ack: wb_ack_i asserted while not in BUSY is ignored.
- Reset mid-transfer: bus drops immediately on the reset edge; the slave must tolerate the cyc drop.

Test Plan:
1. Read, ack on 3rd BUSY cycle, stall_i=0:
   - Stimulus: ce=1, we=0, addr=0x0000_0040, sel=4'hF; slave returns 0xDEAD_BEEF.
   - Required: wb_adr_o=0x40 and cyc=stb=1 for 3 cycles; stallreq=1 until the ack cycle; cpu_data_o=0xDEADBEEF in the ack cycle; IDLE next.
2. Write with byte lane:
   - Stimulus: we=1, sel=4'b0010, addr=0x44, data=0x0000_AB00; ack after 1 cycle.
   - Required: wb_we_o=1, wb_sel_o=4'b0010, wb_dat_o=0x0000AB00; cpu_data_o=0 throughout.
3. Read acked while stall_i=6'b001111:
   - Required: FSM in WAIT_STALL; cpu_data_o holds the captured value 0x1234_5678 while stalled; returns to IDLE the cycle after stall_i=0.
4. Flush in BUSY:
   - Stimulus: flush_i=1 on the 2nd BUSY cycle.
   - Required: cyc/stb=0 next edge; state IDLE; stallreq=0; a subsequent ack is ignored.
5. Watchdog:
   - Stimulus: TIMEOUT_CYCLES=4, slave never acks.
   - Required: cyc drops after 4 BUSY cycles; bus_err_o high exactly 1 cycle; cpu_data_o=0.
6. Reset:
   - Stimulus: rst=0 mid-BUSY.
   - Required: all wb_* outputs, bus_err_o and stallreq are 0 after the edge; state IDLE; rd_buf=0.
